idli_alu_acc_m: RTL

Serial ALU sequencer/accumulator directly downstream of the 4b serial ALU. Drives the ALU's carry-in and RHS-invert controls for each nibble and chains the carry between beats. Captures the four 4b result nibbles LSB-first into a 16b result. On completion of a 16b operation it produces Z/N/C/V flags and a one-cycle done pulse.

---
 rtl/idli_pkg.sv | 28 ++
 rtl/idli_alu_acc_m.sv | 131 +++++++++++++
 2 files changed

// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared types for the idli serial datapath
// Nibble, ALU op, accumulator flag and accumulator state types.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD,
    ALU_OP_AND,
    ALU_OP_OR,
    ALU_OP_XOR
  } alu_op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } acc_flags_t;

  localparam int ACC_BEATS = 4;

  typedef enum logic {
    ACC_STATE_IDLE,
    ACC_STATE_RUN
  } acc_state_t;

endpackage

// File: rtl/idli_alu_acc_m.sv
// rtl/idli_alu_acc_m.sv - serial ALU sequencer and 16b result/flag accumulator
// Steers the 4b ALU over four LSB-first beats and publishes result and flags on completion.
module idli_alu_acc_m
  import idli_pkg::*;
(
  input  logic       i_acc_gck,
  input  logic       i_acc_rst_n,
  input  logic       i_acc_start,
  input  alu_op_t    i_acc_op,
  input  logic       i_acc_sub,
  input  logic       i_acc_use_cin,
  input  logic       i_acc_cin_ext,
  input  logic       i_acc_lhs_msb,
  input  logic       i_acc_rhs_msb,
  input  sqi_data_t  i_acc_alu_data,
  input  logic       i_acc_alu_cout,
  output logic       o_acc_alu_cin,
  output logic       o_acc_alu_rhs_inv,
  output logic [1:0] o_acc_beat,
  output logic       o_acc_busy,
  output logic       o_acc_done,
  output logic [15:0] o_acc_result,
  output acc_flags_t o_acc_flags
);

  acc_state_t r_state, w_state_nx;
  logic [1:0]  r_beat, w_beat_nx;
  logic        w_start_beat, w_last_beat, w_active;
  logic        r_carry, r_sub, r_zero, r_done;
  alu_op_t     r_op;
  logic [11:0] r_shift;
  logic [15:0] r_result;
  acc_flags_t  r_flags;
  logic        w_nonzero, w_rhs_msb, w_is_add;

  always_ff @(posedge i_acc_gck or negedge i_acc_rst_n) begin
    if (!i_acc_rst_n) begin
      r_state <= ACC_STATE_IDLE;
      r_beat  <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      r_beat  <= w_beat_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_beat_nx    = r_beat;
    w_start_beat = 1'b0;
    w_last_beat  = 1'b0;
    case (r_state)
      ACC_STATE_IDLE: begin
        if (i_acc_start) begin
          w_start_beat = 1'b1;
          w_state_nx   = ACC_STATE_RUN;
          w_beat_nx    = 2'd1;
        end
      end
      ACC_STATE_RUN: begin
        if (r_beat == 2'(ACC_BEATS - 1)) begin
          w_last_beat = 1'b1;
          w_state_nx  = ACC_STATE_IDLE;
          w_beat_nx   = 2'd0;
        end else begin
          w_beat_nx = r_beat + 2'd1;
        end
      end
      default: begin
        w_state_nx = ACC_STATE_IDLE;
        w_beat_nx  = 2'd0;
      end
    endcase
  end

  assign w_active = w_start_beat | (r_state == ACC_STATE_RUN);

  // Subtract forces carry-in so the inverted RHS becomes a two's complement negate.
  always_comb begin
    o_acc_alu_cin = 1'b0;
    if (w_start_beat) begin
      o_acc_alu_cin = i_acc_sub | (i_acc_use_cin & i_acc_cin_ext);
    end else if (r_state == ACC_STATE_RUN) begin
      o_acc_alu_cin = r_carry;
    end
  end

  assign o_acc_alu_rhs_inv = (r_state == ACC_STATE_RUN) ? r_sub : i_acc_sub;

  assign w_nonzero = (w_start_beat ? 1'b0 : r_zero) | (|i_acc_alu_data);
  assign w_rhs_msb = i_acc_rhs_msb ^ r_sub;
  assign w_is_add  = (r_op == ALU_OP_ADD);

  // Nibbles collect in a staging shift register so the published result holds until the next completion.
  always_ff @(posedge i_acc_gck or negedge i_acc_rst_n) begin
    if (!i_acc_rst_n) begin
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_op     <= ALU_OP_ADD;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
      r_shift  <= 12'h000;
      r_result <= 16'h0000;
      r_flags  <= '0;
    end else begin
      r_done <= w_last_beat;
      if (w_start_beat) begin
        r_op  <= i_acc_op;
        r_sub <= i_acc_sub;
      end
      if (w_active) begin
        r_carry <= i_acc_alu_cout;
        r_shift <= {i_acc_alu_data, r_shift[11:4]};
        r_zero  <= w_nonzero;
      end
      if (w_last_beat) begin
        r_result  <= {i_acc_alu_data, r_shift};
        r_flags.z <= ~w_nonzero;
        r_flags.n <= i_acc_alu_data[3];
        r_flags.c <= w_is_add & i_acc_alu_cout;
        r_flags.v <= w_is_add & (i_acc_lhs_msb == w_rhs_msb) & (i_acc_alu_data[3] != i_acc_lhs_msb);
      end
    end
  end

  assign o_acc_beat   = r_beat;
  assign o_acc_busy   = (r_state == ACC_STATE_RUN);
  assign o_acc_done   = r_done;
  assign o_acc_result = r_result;
  assign o_acc_flags  = r_flags;

endmodule
